// File: rtl/zeta_table_gen.sv
// rtl/zeta_table_gen.sv - sequencer filling the NTT twiddle table with ROOT^brv(k) via an external exponentiation engine
module zeta_table_gen #(
    parameter int               WIDTH  = 24,
    parameter int               LOGN   = 8,
    parameter int               N      = 256,
    parameter logic [WIDTH-1:0] ROOT   = 24'd1753,
    parameter bit               BITREV = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pow_start,
    output logic [WIDTH-1:0] pow_a,
    output logic [WIDTH-1:0] pow_b,
    input  logic             pow_busy,
    input  logic             pow_done,
    input  logic [WIDTH-1:0] pow_res,
    output logic             wr_en,
    output logic [LOGN-1:0]  wr_addr,
    output logic [WIDTH-1:0] wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_DONE
    } state_t;

    // k carries one spare bit so the last-entry compare can never wrap
    localparam logic [LOGN:0] K_LAST = (LOGN+1)'(N - 1);
    localparam logic [LOGN:0] K_ONE  = {{LOGN{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [LOGN:0]    k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pow_start_q, pow_start_d;
    logic [WIDTH-1:0] pow_b_q, pow_b_d;
    logic             wr_en_q, wr_en_d;
    logic [LOGN-1:0]  wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [LOGN-1:0]  exp_idx;

    function automatic logic [LOGN-1:0] brv(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pow_start_d = pow_start_q;
        pow_b_d     = pow_b_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        exp_idx     = BITREV ? brv(k_q[LOGN-1:0]) : k_q[LOGN-1:0];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pow_b_d     = {{(WIDTH-LOGN){1'b0}}, exp_idx};
                pow_start_d = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (pow_done) begin
                    wr_data_d   = pow_res;
                    wr_addr_d   = k_q[LOGN-1:0];
                    wr_en_d     = 1'b1;
                    pow_start_d = 1'b0;
                    state_d     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Wait out the engine's done level so each request yields exactly one result
                if (!pow_done) begin
                    if (k_q == K_LAST) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + K_ONE;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pow_start_q <= 1'b0;
            pow_b_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pow_start_q <= pow_start_d;
            pow_b_q     <= pow_b_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pow_start = pow_start_q;
    assign pow_a     = ROOT;
    assign pow_b     = pow_b_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    a_engine_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_IDLE) |-> !pow_busy);

endmodule

// File: tb/tb_zeta_table_gen.sv
// tb/tb_zeta_table_gen.sv - self-checking bench for zeta_table_gen with a behavioural exponentiation engine
module tb_zeta_table_gen;

    localparam int               WIDTH  = 24;
    localparam int               LOGN   = 8;
    localparam int               N      = 256;
    localparam logic [WIDTH-1:0] ROOT   = 24'd1753;
    localparam longint           Q      = 8380417;
    localparam int               BUDGET = 8000;

    typedef struct {
        logic [LOGN-1:0]  addr;
        logic [WIDTH-1:0] data;
    } exp_t;

    typedef struct {
        int     inst;
        int     k;
        longint pb;
        longint data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic             start_s     [2];
    logic             busy_s      [2];
    logic             done_s      [2];
    logic             pow_start_s [2];
    logic [WIDTH-1:0] pow_a_s     [2];
    logic [WIDTH-1:0] pow_b_s     [2];
    logic             pow_busy_s  [2];
    logic             pow_done_s  [2];
    logic [WIDTH-1:0] pow_res_s   [2];
    logic             wr_en_s     [2];
    logic [LOGN-1:0]  wr_addr_s   [2];
    logic [WIDTH-1:0] wr_data_s   [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    zeta_table_gen #(.WIDTH(WIDTH), .LOGN(LOGN), .N(N), .ROOT(ROOT), .BITREV(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pow_start(pow_start_s[0]), .pow_a(pow_a_s[0]), .pow_b(pow_b_s[0]),
        .pow_busy(pow_busy_s[0]), .pow_done(pow_done_s[0]), .pow_res(pow_res_s[0]),
        .wr_en(wr_en_s[0]), .wr_addr(wr_addr_s[0]), .wr_data(wr_data_s[0])
    );

    zeta_table_gen #(.WIDTH(WIDTH), .LOGN(LOGN), .N(N), .ROOT(ROOT), .BITREV(1'b0)) dut_nat (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pow_start(pow_start_s[1]), .pow_a(pow_a_s[1]), .pow_b(pow_b_s[1]),
        .pow_busy(pow_busy_s[1]), .pow_done(pow_done_s[1]), .pow_res(pow_res_s[1]),
        .wr_en(wr_en_s[1]), .wr_addr(wr_addr_s[1]), .wr_data(wr_data_s[1])
    );

    function automatic longint modpow(input longint e_in);
        longint r, b, e;
        r = 1;
        b = longint'(ROOT);
        e = e_in;
        while (e > 0) begin
            if (e[0]) r = (r * b) % Q;
            b = (b * b) % Q;
            e = e >>> 1;
        end
        return r;
    endfunction

    function automatic int brv8(input int v);
        int r;
        r = 0;
        for (int i = 0; i < LOGN; i++) begin
            if (v[i]) r = r | (1 << (LOGN - 1 - i));
        end
        return r;
    endfunction

    function automatic int exp_of(input int inst, input int k);
        return (inst == 0) ? brv8(k) : k;
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Engine model: 5-cycle compute, done level held until start drops plus 1 + extra_hold cycles
    int               extra_hold [2];
    logic             e_run      [2];
    int               e_cnt      [2];
    int               e_rel      [2];
    logic [WIDTH-1:0] e_b        [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                e_run[i] <= 1'b0; e_cnt[i] <= 0; e_rel[i] <= 0; e_b[i] <= '0;
                pow_done_s[i] <= 1'b0; pow_busy_s[i] <= 1'b0; pow_res_s[i] <= '0;
            end else if (!e_run[i] && !pow_done_s[i] && pow_start_s[i]) begin
                e_run[i] <= 1'b1; e_cnt[i] <= 5; e_b[i] <= pow_b_s[i]; pow_busy_s[i] <= 1'b1;
            end else if (e_run[i]) begin
                if (e_cnt[i] == 1) begin
                    e_run[i] <= 1'b0;
                    pow_done_s[i] <= 1'b1;
                    pow_res_s[i] <= WIDTH'(modpow(longint'(e_b[i])));
                    e_rel[i] <= 1 + extra_hold[i];
                end else begin
                    e_cnt[i] <= e_cnt[i] - 1;
                end
            end else if (pow_done_s[i] && !pow_start_s[i]) begin
                if (e_rel[i] == 0) begin
                    pow_done_s[i] <= 1'b0; pow_busy_s[i] <= 1'b0;
                end else begin
                    e_rel[i] <= e_rel[i] - 1;
                end
            end
        end
    end

    exp_t             q0 [$];
    exp_t             q1 [$];
    logic             prev_ps   [2];
    logic             prev_busy [2];
    int               wr_cnt    [2];
    int               done_cnt  [2];
    logic [WIDTH-1:0] tbl       [2][N];
    logic [WIDTH-1:0] pb_log    [2][N];

    initial begin
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i] = 0; done_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        bit   empty;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                prev_ps[i] <= 1'b0; prev_busy[i] <= 1'b0;
            end
            q0.delete(); q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pow_start_s[i] && !prev_ps[i])
                    chk(!pow_done_s[i], "pow_start_rise_while_done", longint'(pow_done_s[i]), 0);
                if (wr_en_s[i]) begin
                    empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
                    if (empty) begin
                        chk(1'b0, "unexpected_write_addr", longint'(wr_addr_s[i]), -1);
                    end else begin
                        if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
                        chk(wr_addr_s[i] == e.addr, "wr_addr", longint'(wr_addr_s[i]), longint'(e.addr));
                        chk(wr_data_s[i] == e.data, "wr_data", longint'(wr_data_s[i]), longint'(e.data));
                        chk(pow_b_s[i] == WIDTH'(exp_of(i, int'(wr_addr_s[i]))), "pow_b",
                            longint'(pow_b_s[i]), longint'(exp_of(i, int'(wr_addr_s[i]))));
                    end
                    tbl[i][wr_addr_s[i]]    <= wr_data_s[i];
                    pb_log[i][wr_addr_s[i]] <= pow_b_s[i];
                    wr_cnt[i] <= wr_cnt[i] + 1;
                end
                if (done_s[i]) begin
                    done_cnt[i] <= done_cnt[i] + 1;
                    chk(!busy_s[i] && prev_busy[i], "busy_falls_with_done",
                        longint'({prev_busy[i], busy_s[i]}), 2);
                end
                prev_ps[i]   <= pow_start_s[i];
                prev_busy[i] <= busy_s[i];
            end
        end
    end

    int base_wr   [2];
    int base_done [2];

    task automatic begin_run(input bit both);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            base_wr[i] = wr_cnt[i]; base_done[i] = done_cnt[i];
        end
        for (int k = 0; k < N; k++) begin
            e.addr = LOGN'(k);
            e.data = WIDTH'(modpow(longint'(exp_of(0, k))));
            q0.push_back(e);
            if (both) begin
                e.data = WIDTH'(modpow(longint'(exp_of(1, k))));
                q1.push_back(e);
            end
        end
        @(negedge clk);
        start_s[0] = 1'b1; start_s[1] = both;
        @(negedge clk);
        start_s[0] = 1'b0; start_s[1] = 1'b0;
    endtask

    task automatic end_run(input bit both);
        int n;
        n = 0;
        while (n < BUDGET && !(done_cnt[0] > base_done[0] && (!both || done_cnt[1] > base_done[1]))) begin
            @(negedge clk);
            n++;
        end
        chk(n < BUDGET, "done_timeout", n, BUDGET);
        repeat (20) @(negedge clk);
        for (int i = 0; i <= (both ? 1 : 0); i++) begin
            chk(wr_cnt[i] - base_wr[i] == N, "write_count", wr_cnt[i] - base_wr[i], N);
            chk(done_cnt[i] - base_done[i] == 1, "done_count", done_cnt[i] - base_done[i], 1);
            chk(((i == 0) ? q0.size() : q1.size()) == 0, "missing_writes",
                (i == 0) ? q0.size() : q1.size(), 0);
            chk(!busy_s[i] && !pow_start_s[i], "idle_after_done",
                longint'({busy_s[i], pow_start_s[i]}), 0);
        end
    endtask

    task automatic wait_write(input int addr);
        int n;
        n = 0;
        while (n < BUDGET && !(wr_en_s[0] && wr_addr_s[0] == LOGN'(addr))) begin
            @(negedge clk);
            n++;
        end
        chk(n < BUDGET, "wait_write_timeout", n, BUDGET);
    endtask

    vec_t vecs [8];

    initial begin : stim
        int     n;
        longint a, b;
        vecs[0] = '{0, 0,   0,   1};
        vecs[1] = '{0, 1,   128, modpow(128)};
        vecs[2] = '{0, 2,   64,  modpow(64)};
        vecs[3] = '{0, 255, 255, modpow(255)};
        vecs[4] = '{1, 0,   0,   1};
        vecs[5] = '{1, 1,   1,   1753};
        vecs[6] = '{1, 2,   2,   3073009};
        vecs[7] = '{1, 255, 255, modpow(255)};

        start_s[0] = 1'b0; start_s[1] = 1'b0;
        extra_hold[0] = 0; extra_hold[1] = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk({busy_s[i], done_s[i], pow_start_s[i], wr_en_s[i]} == 4'b0, "reset_flags",
                longint'({busy_s[i], done_s[i], pow_start_s[i], wr_en_s[i]}), 0);
            chk(pow_b_s[i] == '0 && wr_addr_s[i] == '0 && wr_data_s[i] == '0, "reset_data",
                longint'(pow_b_s[i]) + longint'(wr_addr_s[i]) + longint'(wr_data_s[i]), 0);
            chk(pow_a_s[i] == ROOT, "pow_a_root", longint'(pow_a_s[i]), longint'(ROOT));
        end
        rst_n = 1'b1;
        @(negedge clk);

        begin_run(1'b1);
        end_run(1'b1);
        for (int v = 0; v < 8; v++) begin
            chk(pb_log[vecs[v].inst][vecs[v].k] == WIDTH'(vecs[v].pb), "vec_pow_b",
                longint'(pb_log[vecs[v].inst][vecs[v].k]), vecs[v].pb);
            chk(tbl[vecs[v].inst][vecs[v].k] == WIDTH'(vecs[v].data), "vec_data",
                longint'(tbl[vecs[v].inst][vecs[v].k]), vecs[v].data);
        end
        a = longint'(tbl[0][1]);
        b = longint'(tbl[0][2]);
        chk((a * a) % Q == Q - 1, "root256_is_minus1", (a * a) % Q, Q - 1);
        chk((b * b) % Q == a, "zeta2_sq_is_zeta1", (b * b) % Q, a);

        extra_hold[0] = 3;
        begin_run(1'b0);
        end_run(1'b0);
        extra_hold[0] = 0;

        begin_run(1'b0);
        wait_write(100);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        n = 0;
        while (n < BUDGET && !done_s[0]) begin
            @(negedge clk);
            n++;
        end
        chk(n < BUDGET, "repulse_done_timeout", n, BUDGET);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        end_run(1'b0);

        begin_run(1'b0);
        wait_write(37);
        #1 rst_n = 1'b0;
        #1;
        chk({busy_s[0], done_s[0], pow_start_s[0], wr_en_s[0]} == 4'b0, "async_reset_flags",
            longint'({busy_s[0], done_s[0], pow_start_s[0], wr_en_s[0]}), 0);
        chk(pow_b_s[0] == '0 && wr_addr_s[0] == '0 && wr_data_s[0] == '0, "async_reset_data",
            longint'(pow_b_s[0]) + longint'(wr_addr_s[0]) + longint'(wr_data_s[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk(!busy_s[0] && !pow_start_s[0], "idle_after_reset",
            longint'({busy_s[0], pow_start_s[0]}), 0);
        begin_run(1'b0);
        end_run(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
